// File: rtl/axi_slice_dc_pwr_pkg.sv
// Shared types and sizing helpers for the dual-clock AXI slice power controller.
package axi_slice_dc_pwr_pkg;

    typedef enum logic [2:0] {
        ACTIVE,
        DRAIN,
        ISOLATE,
        SLEEP,
        WAKE
    } pwr_state_e;

    // The delay counter is loaded with (delay - 1), so it only has to hold max(delay) - 1.
    function automatic int dly_cnt_w(input int gate_d, input int wake_d);
        int m;
        m = (gate_d > wake_d) ? gate_d : wake_d;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/axi_txn_counter.sv
// Saturating outstanding-transaction counter; err_o pulses on overflow/underflow attempts.
module axi_txn_counter #(
    parameter int unsigned CNT_W = 5,
    parameter int unsigned MAX   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o,
    output logic             err_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_W'(MAX)) err_o = 1'b1;
            else                      cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_o = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/axi_slice_dc_pwr_ctrl.sv
// Drains outstanding downstream AXI traffic, then clock-downs, isolates and gates the master side;
// reverses the sequence on wake.
module axi_slice_dc_pwr_ctrl
    import axi_slice_dc_pwr_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16,
    parameter int GATE_DELAY      = 2,
    parameter int WAKE_DELAY      = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sleep_req_i,
    output logic sleep_ack_o,
    input  logic incoming_req_i,
    input  logic aw_valid_i,
    input  logic aw_ready_i,
    input  logic w_valid_i,
    input  logic w_ready_i,
    input  logic w_last_i,
    input  logic ar_valid_i,
    input  logic ar_ready_i,
    input  logic r_valid_i,
    input  logic r_ready_i,
    input  logic r_last_i,
    input  logic b_valid_i,
    input  logic b_ready_i,
    output logic clock_down_o,
    output logic isolate_o,
    output logic clk_en_o,
    output logic busy_o,
    output logic err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int DW    = dly_cnt_w(GATE_DELAY, WAKE_DELAY);

    logic aw_hs, w_hs, ar_hs, r_hs, b_hs;
    assign aw_hs = aw_valid_i & aw_ready_i;
    assign w_hs  = w_valid_i & w_ready_i;
    assign ar_hs = ar_valid_i & ar_ready_i;
    assign r_hs  = r_valid_i & r_ready_i;
    assign b_hs  = b_valid_i & b_ready_i;

    // Index 0: write responses, 1: write data bursts, 2: read bursts.
    logic [2:0]            inc, dec, zero, cnt_err;
    logic [2:0][CNT_W-1:0] cnt;
    assign inc = {ar_hs, aw_hs, aw_hs};
    assign dec = {r_hs & r_last_i, w_hs & w_last_i, b_hs};

    for (genvar i = 0; i < 3; i++) begin : g_cnt
        axi_txn_counter #(
            .CNT_W(CNT_W),
            .MAX  (MAX_OUTSTANDING)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .inc_i (inc[i]),
            .dec_i (dec[i]),
            .cnt_o (cnt[i]),
            .zero_o(zero[i]),
            .err_o (cnt_err[i])
        );
    end

    assign busy_o = (cnt[0] != '0) | (cnt[1] != '0) | (cnt[2] != '0);

    pwr_state_e    state_q;
    logic [DW-1:0] dly_q;
    logic          clock_down_q, isolate_q, clk_en_q, sleep_ack_q, err_q;
    logic          wake, iso_err;

    assign wake    = incoming_req_i | ~sleep_req_i;
    assign iso_err = isolate_q & (aw_hs | ar_hs | w_hs | r_valid_i | b_valid_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ACTIVE;
            dly_q        <= '0;
            clock_down_q <= 1'b0;
            isolate_q    <= 1'b0;
            clk_en_q     <= 1'b1;
            sleep_ack_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if ((|cnt_err) | iso_err) err_q <= 1'b1;
            unique case (state_q)
                ACTIVE: if (sleep_req_i) state_q <= DRAIN;
                DRAIN: begin
                    if (!sleep_req_i) begin
                        state_q <= ACTIVE;
                    end else if ((&zero) && !aw_hs && !ar_hs) begin
                        // A new AW/AR this cycle would be in flight behind the isolation.
                        state_q      <= ISOLATE;
                        clock_down_q <= 1'b1;
                        isolate_q    <= 1'b1;
                        dly_q        <= DW'(GATE_DELAY - 1);
                    end
                end
                ISOLATE: begin
                    if (wake) begin
                        state_q <= WAKE;
                        dly_q   <= DW'(WAKE_DELAY - 1);
                    end else if (dly_q == '0) begin
                        state_q     <= SLEEP;
                        clk_en_q    <= 1'b0;
                        sleep_ack_q <= 1'b1;
                    end else begin
                        dly_q <= dly_q - DW'(1);
                    end
                end
                SLEEP: begin
                    if (wake) begin
                        state_q     <= WAKE;
                        clk_en_q    <= 1'b1;
                        sleep_ack_q <= 1'b0;
                        dly_q       <= DW'(WAKE_DELAY - 1);
                    end
                end
                WAKE: begin
                    if (dly_q == '0) begin
                        state_q      <= ACTIVE;
                        clock_down_q <= 1'b0;
                        isolate_q    <= 1'b0;
                    end else begin
                        dly_q <= dly_q - DW'(1);
                    end
                end
                default: state_q <= ACTIVE;
            endcase
        end
    end

    assign clock_down_o = clock_down_q;
    assign isolate_o    = isolate_q;
    assign clk_en_o     = clk_en_q;
    assign sleep_ack_o  = sleep_ack_q;
    assign err_o        = err_q;

endmodule
